// File: rtl/ccff_loader_pkg.sv
// Shared types and chain-geometry helper for the ccff bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {IDLE, HDR, LOAD, FIN} state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef struct packed {
    logic [15:0] byte_count;
    logic [3:0]  last_bits;
  } chain_geom_t;

  // Bytes needed to fill the chain, and how many bits of the final byte are used.
  function automatic chain_geom_t chain_geom(input int chain_len);
    chain_geom_t g;
    g.byte_count = 16'((chain_len + 7) / 8);
    g.last_bits  = ((chain_len % 8) == 0) ? 4'd8 : 4'(chain_len % 8);
    return g;
  endfunction

endpackage

// File: rtl/ccff_byte_serializer.sv
// Accepts bytes over valid/ready and hands out one bit per cycle, LSB first,
// truncating the final byte of a load to its used bit count.
module ccff_byte_serializer
  import ccff_loader_pkg::*;
#(
  parameter int BYTE_COUNT = 8,
  parameter int LAST_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       bit_out,
  output logic       bit_valid
);

  localparam int                BYTE_W    = $clog2(BYTE_COUNT + 1);
  localparam logic [BYTE_W-1:0] BYTES_L   = BYTE_W'(BYTE_COUNT);
  localparam logic [BYTE_W-1:0] LAST_IDX  = BYTE_W'(BYTE_COUNT - 1);
  localparam logic [2:0]        LAST_LEFT = 3'(LAST_BITS - 1);

  logic [6:0]        sr_reg, sr_next;
  logic [2:0]        left_reg, left_next;
  logic [BYTE_W-1:0] count_reg, count_next;
  logic              ready_reg, ready_next;
  logic              accept;

  assign accept   = in_valid & ready_reg;
  assign in_ready = ready_reg;

  always_comb begin
    sr_next    = sr_reg;
    left_next  = left_reg;
    count_next = count_reg;
    bit_out    = 1'b0;
    bit_valid  = 1'b0;
    if (arm) begin
      count_next = '0;
      left_next  = '0;
    end else if (accept) begin
      // Bit 0 goes out on the accepting edge so streaming needs no bubble.
      bit_out    = in_data[0];
      bit_valid  = 1'b1;
      sr_next    = in_data[7:1];
      left_next  = (count_reg == LAST_IDX) ? LAST_LEFT : 3'd7;
      count_next = count_reg + 1'b1;
    end else if (left_reg != 3'd0) begin
      bit_out    = sr_reg[0];
      bit_valid  = 1'b1;
      sr_next    = {1'b0, sr_reg[6:1]};
      left_next  = left_reg - 3'd1;
    end
    ready_next = arm | ((ready_reg | (count_reg != '0)) & (left_next == 3'd0) &
                        (count_next != BYTES_L));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg    <= '0;
      left_reg  <= '0;
      count_reg <= '0;
      ready_reg <= 1'b0;
    end else begin
      sr_reg    <= sr_next;
      left_reg  <= left_next;
      count_reg <= count_next;
      ready_reg <= ready_next;
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Loads a configuration chain: header byte, then CHAIN_LEN data bits, checking
// that the header emerges intact at the chain tail.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int         CHAIN_LEN = 64,
  parameter logic [7:0] HEADER    = DEFAULT_HEADER,
  parameter int         CNT_W     = $clog2(CHAIN_LEN + 9)
) (
  input  logic       prog_clk,
  input  logic       prog_reset_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam chain_geom_t      GEOM        = chain_geom(CHAIN_LEN);
  localparam logic [CNT_W-1:0] FIRST_CHECK = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_SHIFT  = CNT_W'(CHAIN_LEN + 7);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mismatch_reg, mismatch_next;
  logic             head_reg, head_next;
  logic             shift_en_reg, shift_en_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;
  logic             arm;
  logic             ser_bit, ser_valid;
  logic [2:0]       check_idx;
  logic             tail_bad;

  ccff_byte_serializer #(
    .BYTE_COUNT(int'(GEOM.byte_count)),
    .LAST_BITS (int'(GEOM.last_bits))
  ) u_serializer (
    .clk      (prog_clk),
    .rst_n    (prog_reset_n),
    .arm      (arm),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bit_out  (ser_bit),
    .bit_valid(ser_valid)
  );

  // cnt_reg is the index j of the shift currently presented; from j=CHAIN_LEN on
  // the header bits shifted first should be falling out of the tail.
  assign check_idx = 3'(cnt_reg - FIRST_CHECK);
  assign tail_bad  = shift_en_reg && (cnt_reg >= FIRST_CHECK) && (cnt_reg <= LAST_SHIFT) &&
                     (ccff_tail != HEADER[check_idx]);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = shift_en_reg ? cnt_reg + 1'b1 : cnt_reg;
    mismatch_next = mismatch_reg | tail_bad;
    head_next     = 1'b0;
    shift_en_next = 1'b0;
    busy_next     = busy_reg;
    done_next     = done_reg;
    error_next    = error_reg;
    arm           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = HDR;
          cnt_next      = '0;
          mismatch_next = 1'b0;
          done_next     = 1'b0;
          error_next    = 1'b0;
          busy_next     = 1'b1;
          head_next     = HEADER[0];
          shift_en_next = 1'b1;
        end
      end
      HDR: begin
        if (cnt_reg[2:0] == 3'd7) begin
          state_next = LOAD;
          arm        = 1'b1;
        end else begin
          head_next     = HEADER[cnt_reg[2:0] + 3'd1];
          shift_en_next = 1'b1;
        end
      end
      LOAD: begin
        head_next     = ser_bit;
        shift_en_next = ser_valid;
        if (shift_en_reg && (cnt_reg == LAST_SHIFT)) begin
          state_next    = FIN;
          head_next     = 1'b0;
          shift_en_next = 1'b0;
          busy_next     = 1'b0;
          done_next     = 1'b1;
          error_next    = mismatch_reg | tail_bad;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      mismatch_reg <= 1'b0;
      head_reg     <= 1'b0;
      shift_en_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      mismatch_reg <= mismatch_next;
      head_reg     <= head_next;
      shift_en_reg <= shift_en_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  assign ccff_head     = head_reg;
  assign ccff_shift_en = shift_en_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: two loaders (20-bit and 5-bit chains) driving behavioural chains.
module tb_ccff_bitstream_loader;
  import ccff_loader_pkg::*;

  localparam int         N0       = 20;
  localparam int         N1       = 5;
  localparam logic [7:0] HDR_BYTE = DEFAULT_HEADER;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n[2];
  logic       start[2];
  logic [7:0] in_data[2];
  logic       in_valid[2];
  logic       in_ready[2];
  logic       head[2];
  logic       shift_en[2];
  logic       tail[2];
  logic       busy[2];
  logic       done[2];
  logic       error[2];
  logic [63:0] chain_m[2];
  logic       stuck[2];

  typedef struct {
    logic        err;
    int          shifts;
    logic [63:0] content;
    int          nbytes;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int shifts[2];
  int accs[2];
  logic done_prev[2];

  ccff_bitstream_loader #(.CHAIN_LEN(N0)) dut0 (
    .prog_clk(clk), .prog_reset_n(rst_n[0]), .start(start[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .ccff_head(head[0]),
    .ccff_shift_en(shift_en[0]), .ccff_tail(tail[0]), .busy(busy[0]), .done(done[0]),
    .error(error[0]));

  ccff_bitstream_loader #(.CHAIN_LEN(N1)) dut1 (
    .prog_clk(clk), .prog_reset_n(rst_n[1]), .start(start[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .ccff_head(head[1]),
    .ccff_shift_en(shift_en[1]), .ccff_tail(tail[1]), .busy(busy[1]), .done(done[1]),
    .error(error[1]));

  // Behavioural chain: position 0 at the head, position N-1 drives the tail.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      if (shift_en[u]) chain_m[u] <= {chain_m[u][62:0], head[u]};
  end

  always_comb begin
    tail[0] = stuck[0] ? 1'b0 : chain_m[0][N0-1];
    tail[1] = stuck[1] ? 1'b0 : chain_m[1][N1-1];
  end

  function automatic int nlen(input int u);
    return (u == 0) ? N0 : N1;
  endfunction

  // Chain read back as a data word: bit i is the i-th data bit shifted in.
  function automatic logic [63:0] observed(input int u);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nlen(u); i++) v[i] = chain_m[u][nlen(u)-1-i];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: samples just after the falling edge, pops the scoreboard on each done rise.
  always begin
    @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n[u]) begin
        shifts[u] = 0;
        accs[u] = 0;
        done_prev[u] = 1'b0;
      end else begin
        if (shift_en[u]) begin
          if (shifts[u] >= 8) begin
            int avail;
            avail = accs[u] * 8;
            if (avail > nlen(u)) avail = nlen(u);
            avail = avail - (shifts[u] - 8);
            check($sformatf("u%0d shift_en_without_data", u), 64'(avail > 0), 64'd1);
          end
          shifts[u]++;
        end
        if (in_valid[u] && in_ready[u]) accs[u]++;
        if (done[u] && !done_prev[u]) begin
          exp_t e;
          int qsz;
          qsz = (u == 0) ? exp_q0.size() : exp_q1.size();
          check($sformatf("u%0d done_expected", u), 64'(qsz > 0), 64'd1);
          if (qsz > 0) begin
            e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("u%0d error", u), 64'(error[u]), 64'(e.err));
            check($sformatf("u%0d shift_count", u), 64'(shifts[u]), 64'(e.shifts));
            check($sformatf("u%0d chain_content", u), observed(u), e.content);
            check($sformatf("u%0d bytes_accepted", u), 64'(accs[u]), 64'(e.nbytes));
            $display("u%0d load: shifts=%0d bytes=%0d chain=0x%0h error=%0b", u, shifts[u],
                     accs[u], observed(u), error[u]);
          end
          shifts[u] = 0;
          accs[u] = 0;
        end
        done_prev[u] = done[u];
      end
    end
  end

  task automatic pulse_start(input int u);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
  endtask

  task automatic send_byte(input int u, input logic [7:0] b, input int gap);
    int t;
    in_valid[u] = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid[u] = 1'b1;
    in_data[u] = b;
    t = 0;
    while (!in_ready[u] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("u%0d accept_timeout", u), 64'(t >= 300), 64'd0);
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_data[u] = 8'($urandom);
  endtask

  task automatic wait_done(input int u);
    int t;
    t = 0;
    while (!done[u] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("u%0d done_timeout", u), 64'(t >= 400), 64'd0);
    in_valid[u] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic exp_t make_exp(input int u, input logic [63:0] data, input int nb,
                                    input logic stuck_v);
    exp_t e;
    e.err = stuck_v && (HDR_BYTE != 8'h00);
    e.shifts = nlen(u) + 8;
    e.content = data & ((64'd1 << nlen(u)) - 64'd1);
    e.nbytes = nb;
    return e;
  endfunction

  task automatic run_load(input int u, input logic [63:0] data, input int nb, input int maxgap,
                          input logic stuck_v, input logic extra, input logic mid_start);
    exp_t e;
    e = make_exp(u, data, nb, stuck_v);
    stuck[u] = stuck_v;
    if (u == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    pulse_start(u);
    for (int i = 0; i < nb; i++) begin
      send_byte(u, data[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      if (mid_start && i == 0) pulse_start(u);
    end
    if (extra) begin
      in_valid[u] = 1'b1;
      in_data[u] = 8'($urandom);
    end
    wait_done(u);
  endtask

  task automatic check_quiet(input int u, input string tag);
    check($sformatf("u%0d %s outputs", u, tag),
          64'({in_ready[u], head[u], shift_en[u], busy[u], done[u], error[u]}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0;
      start[u] = 1'b0;
      in_data[u] = 8'h00;
      in_valid[u] = 1'b0;
      stuck[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #2;
    check_quiet(0, "reset");
    check_quiet(1, "reset");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);

    // Directed loads on the 20-bit chain.
    run_load(0, 64'h05_3412, 3, 0, 1'b0, 1'b0, 1'b0);
    run_load(0, 64'h05_3412, 3, 0, 1'b1, 1'b0, 1'b0);
    run_load(0, 64'h05_3412, 3, 5, 1'b0, 1'b0, 1'b0);

    // Reset after about ten shifts, then a full reload.
    begin
      int t;
      exp_q0.push_back(make_exp(0, 64'h05_3412, 3, 1'b0));
      stuck[0] = 1'b0;
      pulse_start(0);
      send_byte(0, 8'h12, 0);
      t = 0;
      while (shifts[0] < 10 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("u0 reach_10_shifts_timeout", 64'(t >= 100), 64'd0);
      rst_n[0] = 1'b0;
      exp_q0.delete();
      @(negedge clk);
      #2;
      check_quiet(0, "mid_load_reset");
      rst_n[0] = 1'b1;
      repeat (2) @(negedge clk);
    end
    run_load(0, 64'h05_3412, 3, 0, 1'b0, 1'b0, 1'b0);

    // Start pulsed mid-load and a fourth byte offered after the third.
    run_load(0, 64'h05_3412, 3, 0, 1'b0, 1'b1, 1'b1);

    // 5-bit chain: header check window overlaps the header shifts.
    run_load(1, 64'hFF, 1, 0, 1'b0, 1'b0, 1'b0);
    run_load(1, 64'hFF, 1, 0, 1'b1, 1'b0, 1'b0);

    // Randomized loads on both chains.
    for (int k = 0; k < 6; k++) begin
      logic [63:0] d;
      d = 64'($urandom) & 64'hFF_FFFF;
      run_load(0, d, 3, int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) == 0), 1'b0, 1'b0);
      d = 64'($urandom) & 64'hFF;
      run_load(1, d, 1, int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), 1'b0);
    end

    check("u0 scoreboard_drained", 64'(exp_q0.size()), 64'd0);
    check("u1 scoreboard_drained", 64'(exp_q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
